// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Operand forwarding and load-use stall control for an in-order pipeline.
//   For each read port the operand is taken from the youngest stage that
//   writes the same register (EXE > MEM > WB), then from a one-cycle shadow
//   of the previous WB write, and otherwise from the register file.
//   A load in EXE whose destination is needed by a used port raises stall;
//   LOAD_LAT > 1 keeps stall high for the remaining cycles in a small FSM.
//
// Parameters: XLEN (data width), NPORTS (read ports, 1..4),
//             LOAD_LAT (total load-use stall cycles, 1..4)
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rs      [NPORTS*XLEN]      register-file read data, port p at [p*XLEN +: XLEN]
//   addr    [NPORTS*5]         source register index per port
//   used    [NPORTS]           port carries a real source operand
//   rd_*/data_*/Wreg_*         destination, result and write enable of EXE/MEM/WB
//   load_EXE                   EXE instruction is a load (data_EXE not valid yet)
//   rsF     [NPORTS*XLEN]      forwarded operand per port (combinational)
//   fwd_sel [NPORTS*3]         0 regfile, 1 EXE, 2 MEM, 3 WB, 4 shadow (combinational)
//   stall                      freeze fetch/decode, bubble into EXE (combinational)
// Optional build macro HAZARD_FWD_STATS_EN adds:
//   stats_clr                  clear both counters (wins over increment)
//   fwd_count, stall_count     32-bit wrapping counters of forwards / stall cycles
module hazard_forward_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NPORTS   = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS*XLEN-1:0] rs,
    input  logic [NPORTS*5-1:0]    addr,
    input  logic [NPORTS-1:0]      used,
    input  logic [4:0]             rd_EXE,
    input  logic [4:0]             rd_MEM,
    input  logic [4:0]             rd_WB,
    input  logic [XLEN-1:0]        data_EXE,
    input  logic [XLEN-1:0]        data_MEM,
    input  logic [XLEN-1:0]        data_WB,
    input  logic                   Wreg_EXE,
    input  logic                   Wreg_MEM,
    input  logic                   Wreg_WB,
    input  logic                   load_EXE,
    output logic [NPORTS*XLEN-1:0] rsF,
    output logic [NPORTS*3-1:0]    fwd_sel,
`ifdef HAZARD_FWD_STATS_EN
    input  logic                   stats_clr,
    output logic [31:0]            fwd_count,
    output logic [31:0]            stall_count,
`endif
    output logic                   stall
);

    localparam int unsigned RW    = 5;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 3;

    localparam logic [SEL_W-1:0] SEL_RF  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_EXE = 3'd1;
    localparam logic [SEL_W-1:0] SEL_MEM = 3'd2;
    localparam logic [SEL_W-1:0] SEL_WB  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_SH  = 3'd4;

    typedef enum logic {S_IDLE, S_STALL} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                hazard;
    logic [NPORTS-1:0]   port_hazard;
    logic                sh_valid;
    logic [RW-1:0]       sh_rd;
    logic [XLEN-1:0]     sh_data;

    // Shadow of last cycle's WB write: covers a regfile that reads before it writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_valid <= 1'b0;
        end else begin
            sh_valid <= Wreg_WB && (rd_WB != '0);
        end
    end

    always_ff @(posedge clk) begin
        sh_rd   <= rd_WB;
        sh_data <= data_WB;
    end

`ifdef HAZARD_FWD_STATS_EN
    logic [NPORTS-1:0] port_fwd;
`endif

    // Per-port source selection; ports are fully independent.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [RW-1:0]    a;
        logic             hit_exe, hit_mem, hit_wb, hit_sh;
        logic [XLEN-1:0]  data_c;
        logic [SEL_W-1:0] sel_c;

        assign a = addr[p*RW +: RW];

        // A load in EXE has no data yet, so it never forwards; lower stages may.
        assign hit_exe = Wreg_EXE && (rd_EXE == a) && (rd_EXE != '0) && !load_EXE;
        assign hit_mem = Wreg_MEM && (rd_MEM == a) && (rd_MEM != '0);
        assign hit_wb  = Wreg_WB  && (rd_WB  == a) && (rd_WB  != '0);
        assign hit_sh  = sh_valid && (sh_rd  == a);

        always_comb begin
            sel_c  = SEL_RF;
            data_c = rs[p*XLEN +: XLEN];
            if (a == '0) begin
                sel_c  = SEL_RF;
                data_c = '0;
            end else if (hit_exe) begin
                sel_c  = SEL_EXE;
                data_c = data_EXE;
            end else if (hit_mem) begin
                sel_c  = SEL_MEM;
                data_c = data_MEM;
            end else if (hit_wb) begin
                sel_c  = SEL_WB;
                data_c = data_WB;
            end else if (hit_sh) begin
                sel_c  = SEL_SH;
                data_c = sh_data;
            end
        end

        assign rsF[p*XLEN +: XLEN]    = data_c;
        assign fwd_sel[p*SEL_W +: SEL_W] = sel_c;
        assign port_hazard[p] = used[p] && load_EXE && Wreg_EXE &&
                                (rd_EXE != '0) && (rd_EXE == a);
`ifdef HAZARD_FWD_STATS_EN
        assign port_fwd[p] = used[p] && (sel_c != SEL_RF);
`endif
    end

    assign hazard = |port_hazard;

    // Stall FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // First stall cycle comes straight from the hazard; STALL covers the rest.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (hazard) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nxt = S_STALL;
                        cnt_nxt   = CNT_W'(LOAD_LAT - 1);
                    end
                end
            end
            S_STALL: begin
                stall   = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef HAZARD_FWD_STATS_EN
    // Wrapping event counters; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            fwd_count   <= fwd_count + 32'($countones(port_fwd));
            stall_count <= stall_count + 32'(stall);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (LOAD_LAT 3 and 4) share all
// inputs except reset; a behavioural model predicts every output.
module tb_hazard_forward_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NP   = 2;

    logic            clk = 1'b0;
    logic            reset_a, reset_b;
    logic [XLEN-1:0] rs_t [NP];
    logic [4:0]      addr_t [NP];
    logic [NP-1:0]   used;
    logic [NP*XLEN-1:0] rs;
    logic [NP*5-1:0]    addr;
    logic [4:0]      rd_EXE, rd_MEM, rd_WB;
    logic [XLEN-1:0] data_EXE, data_MEM, data_WB;
    logic            Wreg_EXE, Wreg_MEM, Wreg_WB, load_EXE;
    logic            stats_clr;

    logic [NP*XLEN-1:0] rsF_a, rsF_b;
    logic [NP*3-1:0]    sel_a, sel_b;
    logic               stall_a, stall_b;
`ifdef HAZARD_FWD_STATS_EN
    logic [31:0] fwd_count_a, stall_count_a, fwd_count_b, stall_count_b;
`endif

    assign rs   = {rs_t[1], rs_t[0]};
    assign addr = {addr_t[1], addr_t[0]};

    always #5 clk = ~clk;

    hazard_forward_unit #(.XLEN(XLEN), .NPORTS(NP), .LOAD_LAT(3)) u_dut_a (
        .clk(clk), .reset(reset_a), .rs(rs), .addr(addr), .used(used),
        .rd_EXE(rd_EXE), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
        .data_EXE(data_EXE), .data_MEM(data_MEM), .data_WB(data_WB),
        .Wreg_EXE(Wreg_EXE), .Wreg_MEM(Wreg_MEM), .Wreg_WB(Wreg_WB),
        .load_EXE(load_EXE), .rsF(rsF_a), .fwd_sel(sel_a),
`ifdef HAZARD_FWD_STATS_EN
        .stats_clr(stats_clr), .fwd_count(fwd_count_a), .stall_count(stall_count_a),
`endif
        .stall(stall_a)
    );

    hazard_forward_unit #(.XLEN(XLEN), .NPORTS(NP), .LOAD_LAT(4)) u_dut_b (
        .clk(clk), .reset(reset_b), .rs(rs), .addr(addr), .used(used),
        .rd_EXE(rd_EXE), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
        .data_EXE(data_EXE), .data_MEM(data_MEM), .data_WB(data_WB),
        .Wreg_EXE(Wreg_EXE), .Wreg_MEM(Wreg_MEM), .Wreg_WB(Wreg_WB),
        .load_EXE(load_EXE), .rsF(rsF_b), .fwd_sel(sel_b),
`ifdef HAZARD_FWD_STATS_EN
        .stats_clr(stats_clr), .fwd_count(fwd_count_b), .stall_count(stall_count_b),
`endif
        .stall(stall_b)
    );

    int total = 0;
    int bad   = 0;

    // Model state per instance: remaining stall cycles, shadow write, counters.
    int              lat [2] = '{3, 4};
    int              m_rem [2];
    logic            m_shv [2];
    logic [4:0]      m_shrd [2];
    logic [XLEN-1:0] m_shd [2];
    logic [31:0]     m_fwd [2];
    logic [31:0]     m_stc [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operand a port should see: highest-priority matching writer wins.
    function automatic void ref_port(input int inst, input int p,
                                     output logic [XLEN-1:0] d, output logic [2:0] s);
        logic            cv [4];
        logic [4:0]      cr [4];
        logic [XLEN-1:0] cd [4];
        cv = '{Wreg_EXE && !load_EXE, Wreg_MEM, Wreg_WB, m_shv[inst]};
        cr = '{rd_EXE, rd_MEM, rd_WB, m_shrd[inst]};
        cd = '{data_EXE, data_MEM, data_WB, m_shd[inst]};
        d = rs_t[p];
        s = 3'd0;
        if (addr_t[p] == 5'd0) begin
            d = '0;
            return;
        end
        for (int k = 3; k >= 0; k--) begin
            if (cv[k] && cr[k] == addr_t[p]) begin
                d = cd[k];
                s = 3'(k + 1);
            end
        end
    endfunction

    function automatic logic ref_hazard();
        for (int p = 0; p < NP; p++) begin
            if (used[p] && load_EXE && Wreg_EXE && rd_EXE != 5'd0 && addr_t[p] == rd_EXE)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int ref_nfwd(input int inst);
        logic [XLEN-1:0] d;
        logic [2:0]      s;
        int              n;
        n = 0;
        for (int p = 0; p < NP; p++) begin
            ref_port(inst, p, d, s);
            if (used[p] && s != 3'd0) n++;
        end
        return n;
    endfunction

    // Compare every output of both instances against the model.
    task automatic step(input string tag);
        logic [XLEN-1:0] d;
        logic [2:0]      s;
        logic            hz;
        #2;
        hz = ref_hazard();
        for (int p = 0; p < NP; p++) begin
            ref_port(0, p, d, s);
            chk($sformatf("%s_a_rsF%0d", tag, p), 64'(rsF_a[p*XLEN +: XLEN]), 64'(d));
            chk($sformatf("%s_a_sel%0d", tag, p), 64'(sel_a[p*3 +: 3]), 64'(s));
            ref_port(1, p, d, s);
            chk($sformatf("%s_b_rsF%0d", tag, p), 64'(rsF_b[p*XLEN +: XLEN]), 64'(d));
            chk($sformatf("%s_b_sel%0d", tag, p), 64'(sel_b[p*3 +: 3]), 64'(s));
        end
        chk({tag, "_a_stall"}, 64'(stall_a), 64'((m_rem[0] > 0) || hz));
        chk({tag, "_b_stall"}, 64'(stall_b), 64'((m_rem[1] > 0) || hz));
`ifdef HAZARD_FWD_STATS_EN
        chk({tag, "_a_fwdcnt"}, 64'(fwd_count_a), 64'(m_fwd[0]));
        chk({tag, "_a_stlcnt"}, 64'(stall_count_a), 64'(m_stc[0]));
        chk({tag, "_b_fwdcnt"}, 64'(fwd_count_b), 64'(m_fwd[1]));
        chk({tag, "_b_stlcnt"}, 64'(stall_count_b), 64'(m_stc[1]));
`endif
    endtask

    // Advance one clock and move the model with the inputs seen at the edge.
    task automatic tick();
        logic hz;
        logic st [2];
        int   nf [2];
        logic rst;
        hz = ref_hazard();
        for (int i = 0; i < 2; i++) begin
            st[i] = (m_rem[i] > 0) || hz;
            nf[i] = ref_nfwd(i);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            rst = (i == 0) ? reset_a : reset_b;
            if (rst) begin
                m_rem[i] = 0;
                m_shv[i] = 1'b0;
            end else begin
                if (m_rem[i] > 0) m_rem[i]--;
                else if (hz)      m_rem[i] = lat[i] - 1;
                m_shv[i] = Wreg_WB && rd_WB != 5'd0;
            end
            m_shrd[i] = rd_WB;
            m_shd[i]  = data_WB;
            if (rst || stats_clr) begin
                m_fwd[i] = '0;
                m_stc[i] = '0;
            end else begin
                m_fwd[i] = m_fwd[i] + 32'(nf[i]);
                m_stc[i] = m_stc[i] + 32'(st[i]);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < NP; p++) begin
            rs_t[p]   = $urandom;
            addr_t[p] = 5'd0;
        end
        used      = '0;
        rd_EXE    = 5'd0;  rd_MEM   = 5'd0;  rd_WB   = 5'd0;
        data_EXE  = $urandom; data_MEM = $urandom; data_WB = $urandom;
        Wreg_EXE  = 1'b0;  Wreg_MEM = 1'b0;  Wreg_WB = 1'b0;
        load_EXE  = 1'b0;
        stats_clr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick();

        // Reset held: no stall, forwarding still live.
        Wreg_MEM = 1'b1; rd_MEM = 5'd4; data_MEM = 32'h0000_4444;
        addr_t[0] = 5'd4; used = 2'b01;
        step("rst");
        chk("rst_stall_const", 64'(stall_a), 64'(0));
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;

        // EXE beats MEM for the same register.
        idle_inputs();
        addr_t[0] = 5'd5; used = 2'b01;
        Wreg_EXE = 1'b1; rd_EXE = 5'd5; data_EXE = 32'hAA;
        Wreg_MEM = 1'b1; rd_MEM = 5'd5; data_MEM = 32'hBB;
        step("exe_pri");
        chk("exe_pri_rsF0", 64'(rsF_a[31:0]), 64'h0AA);
        chk("exe_pri_sel0", 64'(sel_a[2:0]), 64'd1);
        tick();

        // Register 0 is never forwarded.
        idle_inputs();
        addr_t[1] = 5'd0; used = 2'b10;
        Wreg_EXE = 1'b1; Wreg_MEM = 1'b1; Wreg_WB = 1'b1;
        data_EXE = 32'hFF; data_MEM = 32'hFF; data_WB = 32'hFF;
        step("r0");
        chk("r0_rsF1", 64'(rsF_a[63:32]), 64'd0);
        chk("r0_sel1", 64'(sel_a[5:3]), 64'd0);
        tick();

        // Shadow: WB write this cycle is visible through the shadow next cycle.
        idle_inputs();
        Wreg_WB = 1'b1; rd_WB = 5'd9; data_WB = 32'h1234;
        step("sh_wr");
        tick();
        idle_inputs();
        addr_t[1] = 5'd9; rs_t[1] = 32'd0; used = 2'b10;
        step("sh_rd");
        chk("sh_rsF1", 64'(rsF_a[63:32]), 64'h1234);
        chk("sh_sel1", 64'(sel_a[5:3]), 64'd4);
        tick();

        // Load-use with LOAD_LAT=3: stall for exactly three cycles.
        idle_inputs();
        load_EXE = 1'b1; Wreg_EXE = 1'b1; rd_EXE = 5'd7; data_EXE = 32'hDEAD;
        addr_t[0] = 5'd7; used = 2'b01;
        step("lu0");
        chk("lu_stall_c0", 64'(stall_a), 64'd1);
        chk("lu_no_exe_fwd", 64'(sel_a[2:0]), 64'd0);
        tick();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("lu%0d", i));
            chk($sformatf("lu_stall_c%0d", i), 64'(stall_a), 64'(i < 3));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            step("drain");
            tick();
        end

        // Reset in the second stall cycle of the LOAD_LAT=4 instance.
        load_EXE = 1'b1; Wreg_EXE = 1'b1; rd_EXE = 5'd12;
        addr_t[1] = 5'd12; used = 2'b10;
        step("ra0");
        chk("ra_stall_c0", 64'(stall_b), 64'd1);
        tick();
        idle_inputs();
        reset_b = 1'b1;
        step("ra1");
        chk("ra_stall_c1", 64'(stall_b), 64'd1);
        tick();
        reset_b = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            step($sformatf("ra%0d", i));
            chk($sformatf("ra_stall_c%0d", i), 64'(stall_b), 64'd0);
            tick();
        end

        // Both ports forward from MEM for ten cycles after a clear.
        idle_inputs();
        Wreg_MEM = 1'b1; rd_MEM = 5'd3;
        addr_t[0] = 5'd3; addr_t[1] = 5'd3; used = 2'b11;
        stats_clr = 1'b1;
        step("st_clr");
        tick();
        stats_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("st_run");
            tick();
        end
        step("st_20");
`ifdef HAZARD_FWD_STATS_EN
        chk("st_fwd_20", 64'(fwd_count_a), 64'd20);
`endif
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        step("st_0");
`ifdef HAZARD_FWD_STATS_EN
        chk("st_fwd_0", 64'(fwd_count_a), 64'd0);
`endif
        tick();

        // Randomized traffic over a small register range to force collisions.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                rs_t[p]   = $urandom;
                addr_t[p] = 5'($urandom_range(0, 7));
            end
            used      = 2'($urandom_range(0, 3));
            rd_EXE    = 5'($urandom_range(0, 7));
            rd_MEM    = 5'($urandom_range(0, 7));
            rd_WB     = 5'($urandom_range(0, 7));
            data_EXE  = $urandom; data_MEM = $urandom; data_WB = $urandom;
            Wreg_EXE  = 1'($urandom_range(0, 1));
            Wreg_MEM  = 1'($urandom_range(0, 1));
            Wreg_WB   = 1'($urandom_range(0, 1));
            load_EXE  = ($urandom_range(0, 3) == 0);
            reset_a   = ($urandom_range(0, 60) == 0);
            reset_b   = ($urandom_range(0, 60) == 0);
            stats_clr = ($urandom_range(0, 30) == 0);
            step("rnd");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter XLEN, default 32, operand data width.
REQ-002 Parameter NPORTS, default 2, number of source-operand read ports (1..4).
REQ-003 Parameter LOAD_LAT, default 1, total load-use stall cycles (1..4).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rs  input  NPORTS x XLEN  register-file read data per port.
REQ-007 addr  input  NPORTS x 5  source register index per port.
REQ-008 used  input  NPORTS  port carries a real source operand this cycle.
REQ-009 rd_EXE, rd_MEM, rd_WB  input  5 each  destination index per stage.
REQ-010 data_EXE, data_MEM, data_WB  input  XLEN each  result data per stage.
REQ-011 Wreg_EXE, Wreg_MEM, Wreg_WB  input  1 each  stage writes rd.
REQ-012 load_EXE  input  1  EXE instruction is a load; data_EXE not yet valid.
REQ-013 rsF  output  NPORTS x XLEN  forwarded operand per port.
REQ-014 fwd_sel  output  NPORTS x 3  source chosen: 0 regfile, 1 EXE, 2 MEM, 3 WB, 4 shadow.
REQ-015 stall  output  1  freeze decode/fetch, inject bubble into EXE.

Function
REQ-016 Per port, rsF and fwd_sel SHALL be combinational, priority EXE > MEM > WB > shadow > regfile.
REQ-017 A stage matches a port when its Wreg is 1, its rd equals addr, and rd is nonzero.
REQ-018 addr == 0 SHALL always yield rsF = 0, fwd_sel = 0, regardless of any stage.
REQ-019 EXE match with load_EXE = 1 SHALL NOT forward data_EXE; lower-priority sources apply.
REQ-020 Load-use hazard: state IDLE, load_EXE & Wreg_EXE, rd_EXE nonzero, matches any port with used = 1.
REQ-021 stall SHALL equal (state == IDLE and hazard) or (state == STALL).
REQ-022 FSM IDLE -> STALL on hazard when LOAD_LAT > 1, loading cnt with LOAD_LAT-1; otherwise remain IDLE.
REQ-023 In STALL, cnt SHALL decrement each cycle; STALL -> IDLE on the cycle cnt == 1; new hazards ignored in STALL.
REQ-024 Shadow register: each cycle capture {valid = Wreg_WB & rd_WB != 0, rd_WB, data_WB}; it holds one cycle only.
REQ-025 Shadow matches a port when valid and its rd equals addr (covers regfile read-before-write).
REQ-026 Ports SHALL be resolved independently; the same stage may feed several ports in one cycle.
REQ-027 Unused ports (used = 0) SHALL still produce rsF but SHALL NOT cause stall.

Reset
REQ-028 On reset high at a rising edge: state IDLE, cnt 0, shadow valid 0.
REQ-029 During and after reset, stall SHALL be 0 until a new hazard; combinational rsF unaffected.
REQ-030 Reset asserted mid-STALL SHALL abort the stall on the next edge with no residual cycles.

Configuration
REQ-031 Macro HAZARD_FWD_STATS_EN compiled in: outputs fwd_count and stall_count, 32 bits each, plus input stats_clr.
REQ-032 With the macro: fwd_count += number of ports with used = 1 and fwd_sel != 0 per cycle; stall_count += 1 per stall cycle; both wrap at 2^32, zero on reset or stats_clr (clear wins over increment).
REQ-033 Without the macro: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 addr0=5, Wreg_EXE=1 rd_EXE=5 data_EXE=0xAA, Wreg_MEM=1 rd_MEM=5 data_MEM=0xBB -> rsF0=0xAA, fwd_sel0=1.
REQ-035 addr1=0, all stages rd=0 Wreg=1 data=0xFF -> rsF1=0, fwd_sel1=0.
REQ-036 LOAD_LAT=3, load_EXE=1 rd_EXE=7, addr0=7 used0=1 -> stall high exactly 3 consecutive cycles, then 0.
REQ-037 Cycle n: Wreg_WB=1 rd_WB=9 data_WB=0x1234; cycle n+1: addr1=9, no stage match, rs1=stale 0 -> rsF1=0x1234, fwd_sel1=4.
REQ-038 LOAD_LAT=4, hazard, reset asserted on second stall cycle -> stall 0 from the cycle after reset edge.
REQ-039 HAZARD_FWD_STATS_EN set, NPORTS=2, both ports forward for 10 cycles, then stats_clr -> fwd_count=20 then 0.
